// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory address/data, the decode output slot
// handshake, and the branch/jump redirect request.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_addr,
    input  mem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  mem_addr,
    output mem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, latches each memory word into a
// single valid/ready output slot, and halts once the PC runs past the program.
module imem_fetch_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 17,
  parameter int RESET_PC  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  imem_fetch_ctrl_if.master     bus,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] LP_RESET = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_halted;
  logic [15:0]       r_fetch_count;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_out_valid_nxt;
  logic [31:0]       w_out_instr_nxt;
  logic [ADDR_W-1:0] w_out_pc_nxt;
  logic              w_halted_nxt;
  logic [15:0]       w_fetch_count_nxt;
  logic              w_slot_free;
  logic [15:0]       w_count_inc;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_count_inc = (r_fetch_count == 16'hFFFF) ? r_fetch_count : r_fetch_count + 16'd1;

  // Next-state and next-output decode; redirect outranks fetch in RUN.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_out_valid_nxt   = r_out_valid;
    w_out_instr_nxt   = r_out_instr;
    w_out_pc_nxt      = r_out_pc;
    w_halted_nxt      = r_halted;
    w_fetch_count_nxt = r_fetch_count;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else if (bus.redirect_valid) begin
          w_pc_nxt = bus.redirect_pc;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = bus.redirect_pc;
        end else if (w_slot_free && (r_pc <= LP_LAST)) begin
          w_out_instr_nxt   = bus.mem_instr;
          w_out_pc_nxt      = r_pc;
          w_out_valid_nxt   = 1'b1;
          w_pc_nxt          = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_fetch_count_nxt = w_count_inc;
        end else if (w_slot_free) begin
          // PC ran past the program (or was redirected there): nothing to emit.
          w_out_valid_nxt = 1'b0;
          w_halted_nxt    = 1'b1;
          w_state_nxt     = ST_HALT;
        end else begin
          w_out_valid_nxt = r_out_valid;
        end
      end
      ST_HALT: begin
        w_out_valid_nxt = 1'b0;
        if (start) begin
          w_pc_nxt          = LP_RESET;
          w_fetch_count_nxt = 16'd0;
          w_halted_nxt      = 1'b0;
          w_state_nxt       = ST_RUN;
        end else begin
          w_halted_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output-slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= LP_RESET;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'd0;
      r_out_pc      <= {ADDR_W{1'b0}};
      r_halted      <= 1'b0;
      r_fetch_count <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_halted      <= w_halted_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign bus.mem_addr  = r_pc;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_pc    = r_out_pc;
  assign halted        = r_halted;
  assign fetch_count   = r_fetch_count;

endmodule
